// File: rtl/mux_nto1_hs.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_hs
// Brief    : Registered N:1 mux with valid/ready handshake, fixed or
//            round-robin select. Optional Y_PAR output via MUX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_hs #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N*WIDTH-1:0] I,
    input  logic [N-1:0]       I_VALID,
    output logic [N-1:0]       I_READY,
    input  logic [SEL_W-1:0]   S,
    input  logic               MODE,
    output logic [WIDTH-1:0]   Y,
    output logic [SEL_W-1:0]   Y_CH,
    output logic               Y_VALID,
    input  logic               Y_READY
`ifdef MUX_PARITY_EN
    ,
    output logic               Y_PAR
`endif
);

    localparam logic [SEL_W:0]   c_num_ch = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] c_last   = SEL_W'(N-1);

    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_y_ch;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_rr_hi_ok;
    logic             w_rr_lo_ok;
    logic [SEL_W-1:0] w_rr_hi;
    logic [SEL_W-1:0] w_rr_lo;
    logic             w_rr_ok;
    logic [SEL_W-1:0] w_rr_grant;
    logic [SEL_W-1:0] w_grant;
    logic             w_gnt_ok;
    logic [WIDTH-1:0] w_data;
    logic             w_xfer;
    logic [SEL_W-1:0] w_ptr_next;

    assign w_load_en = !r_y_valid || Y_READY;

    // Round-robin: lowest valid index at/above PTR wins, else lowest below PTR.
    always_comb begin
        w_rr_hi_ok = 1'b0;
        w_rr_lo_ok = 1'b0;
        w_rr_hi    = '0;
        w_rr_lo    = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (I_VALID[k]) begin
                if (SEL_W'(k) >= r_ptr) begin
                    w_rr_hi_ok = 1'b1;
                    w_rr_hi    = SEL_W'(k);
                end else begin
                    w_rr_lo_ok = 1'b1;
                    w_rr_lo    = SEL_W'(k);
                end
            end
        end
    end

    assign w_rr_ok    = w_rr_hi_ok || w_rr_lo_ok;
    assign w_rr_grant = w_rr_hi_ok ? w_rr_hi : w_rr_lo;
    assign w_grant    = MODE ? w_rr_grant : S;
    assign w_gnt_ok   = MODE ? w_rr_ok : ({1'b0, S} < c_num_ch);

    always_comb begin
        I_READY = '0;
        w_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SEL_W'(k)) begin
                I_READY[k] = RST_N && w_load_en && w_gnt_ok;
                w_data     = I[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer     = |(I_VALID & I_READY);
    assign w_ptr_next = (w_grant == c_last) ? '0 : w_grant + SEL_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_ptr     <= '0;
        end else if (w_xfer) begin
            r_y       <= w_data;
            r_y_ch    <= w_grant;
            r_y_valid <= 1'b1;
            if (MODE) begin
                r_ptr <= w_ptr_next;
            end
        end else if (Y_READY) begin
            r_y_valid <= 1'b0;
        end
    end

    assign Y       = r_y;
    assign Y_CH    = r_y_ch;
    assign Y_VALID = r_y_valid;

`ifdef MUX_PARITY_EN
    logic r_par;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_par <= 1'b0;
        end else if (w_xfer) begin
            r_par <= ^w_data;
        end
    end

    assign Y_PAR = r_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nto1_hs
// Brief    : Directed self-checking bench for mux_nto1_hs (N=4 and N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_hs;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;

    logic [31:0] i4;
    logic [3:0]  iv4;
    logic [3:0]  ir4;
    logic [1:0]  s4;
    logic        mode4;
    logic [7:0]  y4;
    logic [1:0]  ych4;
    logic        yv4;
    logic        yr4;
`ifdef MUX_PARITY_EN
    logic        ypar4;
    logic        ypar3;
`endif

    logic [23:0] i3;
    logic [2:0]  iv3;
    logic [2:0]  ir3;
    logic [1:0]  s3;
    logic        mode3;
    logic [7:0]  y3;
    logic [1:0]  ych3;
    logic        yv3;
    logic        yr3;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    mux_nto1_hs #(.WIDTH(8), .N(4), .SEL_W(2)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .I(i4), .I_VALID(iv4), .I_READY(ir4),
        .S(s4), .MODE(mode4), .Y(y4), .Y_CH(ych4), .Y_VALID(yv4), .Y_READY(yr4)
`ifdef MUX_PARITY_EN
        , .Y_PAR(ypar4)
`endif
    );

    mux_nto1_hs #(.WIDTH(8), .N(3), .SEL_W(2)) u_dut3 (
        .CLK(CLK), .RST_N(RST_N), .I(i3), .I_VALID(iv3), .I_READY(ir3),
        .S(s3), .MODE(mode3), .Y(y3), .Y_CH(ych3), .Y_VALID(yv3), .Y_READY(yr3)
`ifdef MUX_PARITY_EN
        , .Y_PAR(ypar3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // channel data: ch3=13, ch2=A5, ch1=11, ch0=10
        i4 = 32'h13A5_1110; iv4 = 4'b1111; s4 = 2'd2; mode4 = 1'b0; yr4 = 1'b1;
        i3 = 24'h0;         iv3 = 3'b000;  s3 = 2'd0; mode3 = 1'b0; yr3 = 1'b0;

        // Reset held: outputs cleared and no ready even with a valid grant
        #2;
        chk("rst_y",      32'(y4),   32'h0);
        chk("rst_yv",     32'(yv4),  32'h0);
        chk("rst_ych",    32'(ych4), 32'h0);
        chk("rst_iready", 32'(ir4),  32'h0);

        // Release with no valid inputs: still no ready
        iv4 = 4'b0000; mode4 = 1'b1;
        tick();
        RST_N = 1'b1;
        #1;
        chk("post_rst_iready", 32'(ir4), 32'h0);

        // Fixed select S=2
        mode4 = 1'b0; s4 = 2'd2; iv4 = 4'b1111; yr4 = 1'b1;
        #1;
        chk("fix_iready", 32'(ir4), 32'b0100);
        tick();
        chk("fix_y",   32'(y4),   32'hA5);
        chk("fix_ych", 32'(ych4), 32'd2);
        chk("fix_yv",  32'(yv4),  32'd1);

        // Backpressure for 3 cycles, next word staged on channel 2
        yr4 = 1'b0; i4 = 32'h135A_1110;
        #1;
        chk("bp_iready0", 32'(ir4), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_y",      32'(y4),  32'hA5);
            chk("bp_yv",     32'(yv4), 32'd1);
            chk("bp_iready", 32'(ir4), 32'h0);
        end
        yr4 = 1'b1;
        #1;
        chk("bp_release_iready", 32'(ir4), 32'b0100);
        tick();
        chk("nobubble_y",  32'(y4),  32'h5A);
        chk("nobubble_yv", 32'(yv4), 32'd1);

        // Drain: valid drops, data and channel stay
        iv4 = 4'b0000;
        tick();
        chk("drain_yv",  32'(yv4),  32'd0);
        chk("drain_y",   32'(y4),   32'h5A);
        chk("drain_ych", 32'(ych4), 32'd2);

        // Round-robin 0,3,0,3,0 starting from PTR=0
        mode4 = 1'b1; iv4 = 4'b1001;
        #1;
        chk("rr_iready_a", 32'(ir4), 32'b0001);
        tick();
        chk("rr_ych_a", 32'(ych4), 32'd0);
        chk("rr_y_a",   32'(y4),   32'h10);
        chk("rr_iready_b", 32'(ir4), 32'b1000);
        tick();
        chk("rr_ych_b", 32'(ych4), 32'd3);
        chk("rr_y_b",   32'(y4),   32'h13);
        chk("rr_iready_c", 32'(ir4), 32'b0001);
        tick();
        chk("rr_ych_c", 32'(ych4), 32'd0);
        chk("rr_iready_d", 32'(ir4), 32'b1000);
        tick();
        chk("rr_ych_d", 32'(ych4), 32'd3);
        chk("rr_iready_e", 32'(ir4), 32'b0001);
        tick();
        chk("rr_ych_e", 32'(ych4), 32'd0);

        // Hold a word (PTR now 1), then reset mid-cycle
        yr4 = 1'b0;
        #1;
        chk("rr_hold_iready", 32'(ir4), 32'h0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_y",      32'(y4),   32'h0);
        chk("midrst_yv",     32'(yv4),  32'h0);
        chk("midrst_ych",    32'(ych4), 32'h0);
        chk("midrst_iready", 32'(ir4),  32'h0);
        tick();
        RST_N = 1'b1;
        #1;
        // PTR back to 0: channel 0 wins over channel 3
        chk("ptr_reset_iready", 32'(ir4), 32'b0001);

        // Parity loads on channel 1 (fixed mode)
        mode4 = 1'b0; s4 = 2'd1; iv4 = 4'b0010; yr4 = 1'b1; i4 = 32'h0000_0700;
        tick();
        chk("par_y07", 32'(y4), 32'h07);
`ifdef MUX_PARITY_EN
        chk("par_07", 32'(ypar4), 32'd1);
`endif
        i4 = 32'h0000_0300;
        tick();
        chk("par_y03", 32'(y4), 32'h03);
`ifdef MUX_PARITY_EN
        chk("par_03", 32'(ypar4), 32'd0);
`endif
        iv4 = 4'b0000;

        // Out-of-range select on the N=3 instance
        i3 = 24'h33_77_11; iv3 = 3'b111; s3 = 2'd1; mode3 = 1'b0; yr3 = 1'b1;
        #1;
        chk("oor_iready_ok", 32'(ir3), 32'b010);
        tick();
        chk("oor_load_y",  32'(y3),  32'h77);
        chk("oor_load_yv", 32'(yv3), 32'd1);
        s3 = 2'd3; yr3 = 1'b0;
        #1;
        chk("oor_iready_hold", 32'(ir3), 32'b000);
        tick();
        chk("oor_hold_yv", 32'(yv3), 32'd1);
        yr3 = 1'b1;
        #1;
        chk("oor_iready", 32'(ir3), 32'b000);
        tick();
        chk("oor_drain_yv", 32'(yv3), 32'd0);
        chk("oor_drain_y",  32'(y3),  32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
